edge_counter_multi: RTL and testbench

Multi-channel, parametrised successor to the single-channel edge-counter controller. Counts edges on `NUM_CH` asynchronous inputs with a per-channel edge mode, gates counting windows from GPO commands, and emits timestamped 128-bit count records to the RTI core FIFO. A round-robin arbiter serialises the records and applies backpressure from the FIFO. The block sits between `GPO_Core` (command source) and `RTI_Core` (record sink) in the RTIO clock domain.

---
 rtl/edge_counter_multi.sv | 178 +++++++++++++++++
 tb/tb_edge_counter_multi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_counter_multi.sv
// Multi-channel edge counter. Counts synchronised input edges in GPO-gated windows and
// emits timestamped 128-bit count records to the RTI FIFO through a round-robin arbiter.
module edge_counter_multi #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic              rtio_clk,
    input  logic              rtio_resetn,
    input  logic [NUM_CH-1:0] input_sig,
    input  logic [63:0]       cmd_in,
    input  logic              valid,
    input  logic [63:0]       counter,
    input  logic              fifo_full,
    output logic              write,
    output logic [127:0]      count_out,
    output logic              busy
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [3:0] OP_START    = 4'd1;
    localparam logic [3:0] OP_STOP     = 4'd2;
    localparam logic [3:0] OP_REPORT   = 4'd3;
    localparam logic [3:0] OP_SET_MODE = 4'd4;

    localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

    // Synchroniser chain: s1/s2 resolve metastability, s3 holds the previous level.
    logic [NUM_CH-1:0]     r_s1, r_s2, r_s3;

    logic [1:0]            r_mode     [NUM_CH];
    logic [NUM_CH-1:0]     r_running;
    logic [DATA_WIDTH-1:0] r_count    [NUM_CH];
    logic [NUM_CH-1:0]     r_sat;

    logic [NUM_CH-1:0]     r_pend;
    logic [DATA_WIDTH-1:0] r_pend_cnt [NUM_CH];
    logic [63:0]           r_pend_ts  [NUM_CH];
    logic [NUM_CH-1:0]     r_pend_sat;
    logic [NUM_CH-1:0]     r_ovr;

    logic [PTR_W-1:0]      r_ptr;

    logic [NUM_CH-1:0]     w_rise, w_fall, w_edge;
    logic [NUM_CH-1:0]     w_mask, w_start, w_stop, w_report, w_set_mode, w_snap;
    logic [DATA_WIDTH-1:0] w_inc_cnt  [NUM_CH];
    logic [NUM_CH-1:0]     w_inc_sat;
    logic [PTR_W:0]        w_cand;
    logic                  w_gnt_any, w_gnt_valid;
    logic [PTR_W-1:0]      w_gnt_ch;
    logic [NUM_CH-1:0]     w_gnt_oh;
    logic [127:0]          w_rec;
    logic                  w_unused_cmd;

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;
    assign w_unused_cmd = ^{cmd_in[63:18], cmd_in[15:4]};

    always_comb begin
        w_mask     = valid ? cmd_in[8 +: NUM_CH] : '0;
        w_start    = (cmd_in[3:0] == OP_START)    ? w_mask : '0;
        w_stop     = (cmd_in[3:0] == OP_STOP)     ? w_mask : '0;
        w_report   = (cmd_in[3:0] == OP_REPORT)   ? w_mask : '0;
        w_set_mode = (cmd_in[3:0] == OP_SET_MODE) ? w_mask : '0;
        w_snap     = w_stop | w_report;
        w_edge     = '0;
        w_inc_sat  = r_sat;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (r_mode[ch])
                2'b00:   w_edge[ch] = w_rise[ch];
                2'b01:   w_edge[ch] = w_fall[ch];
                2'b10:   w_edge[ch] = w_rise[ch] | w_fall[ch];
                default: w_edge[ch] = 1'b0;
            endcase
            w_inc_cnt[ch] = r_count[ch];
            // An edge arriving at all-ones is lost, so it is what marks the count saturated.
            if (r_running[ch] && w_edge[ch]) begin
                if (r_count[ch] == CNT_MAX) begin
                    w_inc_sat[ch] = 1'b1;
                end else begin
                    w_inc_cnt[ch] = r_count[ch] + 1'b1;
                end
            end
        end
    end

    // Round-robin search starting one past the last-granted channel.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_ch  = '0;
        w_cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (w_cand >= (PTR_W+1)'(NUM_CH)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_CH);
            end
            if (!w_gnt_any && r_pend[w_cand[PTR_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_ch  = w_cand[PTR_W-1:0];
            end
        end
        w_gnt_valid        = w_gnt_any & ~fifo_full;
        w_gnt_oh           = '0;
        w_gnt_oh[w_gnt_ch] = w_gnt_valid;

        w_rec                   = '0;
        w_rec[127:64]           = r_pend_ts[w_gnt_ch];
        w_rec[58:56]            = 3'(w_gnt_ch);
        w_rec[49]               = r_ovr[w_gnt_ch];
        w_rec[48]               = r_pend_sat[w_gnt_ch];
        w_rec[DATA_WIDTH-1:0]   = r_pend_cnt[w_gnt_ch];
    end

    always_ff @(posedge rtio_clk or negedge rtio_resetn) begin
        if (!rtio_resetn) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_running  <= '0;
            r_sat      <= '0;
            r_pend     <= '0;
            r_pend_sat <= '0;
            r_ovr      <= '0;
            r_ptr      <= PTR_W'(NUM_CH-1);
            write      <= 1'b0;
            count_out  <= '0;
            busy       <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                r_mode[ch]     <= 2'b00;
                r_count[ch]    <= '0;
                r_pend_cnt[ch] <= '0;
                r_pend_ts[ch]  <= '0;
            end
        end else begin
            r_s1  <= input_sig;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            write <= w_gnt_valid;
            busy  <= |r_pend;
            if (w_gnt_valid) begin
                count_out <= w_rec;
                r_ptr     <= w_gnt_ch;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (w_set_mode[ch]) begin
                    r_mode[ch] <= cmd_in[17:16];
                end
                if (w_start[ch]) begin
                    r_count[ch]   <= '0;
                    r_sat[ch]     <= 1'b0;
                    r_running[ch] <= 1'b1;
                end else begin
                    r_count[ch] <= w_inc_cnt[ch];
                    r_sat[ch]   <= w_inc_sat[ch];
                    if (w_stop[ch]) begin
                        r_running[ch] <= 1'b0;
                    end
                end
                if (w_gnt_oh[ch]) begin
                    r_pend[ch] <= 1'b0;
                    r_ovr[ch]  <= 1'b0;
                end
                // A slot being drained this cycle is free for the new snapshot.
                if (w_snap[ch]) begin
                    if (r_pend[ch] && !w_gnt_oh[ch]) begin
                        r_ovr[ch] <= 1'b1;
                    end else begin
                        r_pend[ch]     <= 1'b1;
                        r_pend_cnt[ch] <= w_inc_cnt[ch];
                        r_pend_ts[ch]  <= counter;
                        r_pend_sat[ch] <= w_inc_sat[ch];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_counter_multi.sv
// Directed bench for edge_counter_multi (4 channels, 4-bit counters): counting, modes,
// saturation, overrun, arbitration, backpressure, edge/command coincidence and reset.
module tb_edge_counter_multi;

    localparam int NUM_CH = 4;
    localparam int DW     = 4;

    logic              rtio_clk = 1'b0;
    logic              rtio_resetn;
    logic [NUM_CH-1:0] input_sig;
    logic [63:0]       cmd_in;
    logic              valid;
    logic [63:0]       counter;
    logic              fifo_full;
    logic              write;
    logic [127:0]      count_out;
    logic              busy;

    int checks  = 0;
    int errors  = 0;
    int bp_viol = 0;
    logic [127:0] got_q[$];
    logic         ff_s;
    logic [127:0] rec;

    edge_counter_multi #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
        .rtio_clk    (rtio_clk),
        .rtio_resetn (rtio_resetn),
        .input_sig   (input_sig),
        .cmd_in      (cmd_in),
        .valid       (valid),
        .counter     (counter),
        .fifo_full   (fifo_full),
        .write       (write),
        .count_out   (count_out),
        .busy        (busy)
    );

    always #5 rtio_clk = ~rtio_clk;

    // Collect every written record; flag any write that follows a full sample.
    always @(posedge rtio_clk) begin
        ff_s = fifo_full;
        #1;
        if (write === 1'b1) begin
            got_q.push_back(count_out);
            if (ff_s) bp_viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mkrec(input logic [63:0] ts, input int ch,
                                           input bit ovr, input bit sat, input int cnt);
        logic [127:0] r;
        r          = '0;
        r[127:64]  = ts;
        r[58:56]   = ch[2:0];
        r[49]      = ovr;
        r[48]      = sat;
        r[DW-1:0]  = cnt[DW-1:0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge rtio_clk);
    endtask

    task automatic cmd(input logic [3:0] op, input logic [7:0] mask,
                       input logic [1:0] mode, input logic [63:0] ts);
        cmd_in  = {46'd0, mode, mask, 4'd0, op};
        valid   = 1'b1;
        counter = ts;
        @(negedge rtio_clk);
        valid   = 1'b0;
        cmd_in  = '0;
    endtask

    task automatic pulse(input int ch);
        input_sig[ch] = 1'b1;
        settle(2);
        input_sig[ch] = 1'b0;
        settle(2);
    endtask

    task automatic get_rec(input string tag, output logic [127:0] r);
        int n;
        n = 0;
        while (got_q.size() == 0 && n < 50) begin
            @(negedge rtio_clk);
            n++;
        end
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=no_record expected=record", tag);
            r = '0;
        end else begin
            r = got_q.pop_front();
        end
    endtask

    initial begin
        rtio_resetn = 1'b0;
        input_sig   = '0;
        cmd_in      = '0;
        valid       = 1'b0;
        counter     = '0;
        fifo_full   = 1'b0;
        settle(3);
        chk("reset_write", {127'd0, write}, 128'd0);
        chk("reset_count_out", count_out, 128'd0);
        chk("reset_busy", {127'd0, busy}, 128'd0);
        rtio_resetn = 1'b1;
        settle(2);

        // START ch0, 10 rising pulses, REPORT with exact write latency
        cmd(4'd1, 8'h01, 2'b00, 64'd0);
        for (int i = 0; i < 10; i++) pulse(0);
        settle(4);
        cmd(4'd3, 8'h01, 2'b00, 64'h1111_0000_0000_0001);
        chk("t1_write_lat0", {127'd0, write}, 128'd0);
        chk("t1_busy_lat0", {127'd0, busy}, 128'd0);
        @(negedge rtio_clk);
        chk("t1_write_lat1", {127'd0, write}, 128'd1);
        chk("t1_busy_lat1", {127'd0, busy}, 128'd1);
        get_rec("t1_get", rec);
        chk("t1_rec", rec, mkrec(64'h1111_0000_0000_0001, 0, 0, 0, 10));
        settle(5);
        chk("t1_single", 128'(got_q.size()), 128'd0);

        // Both-edge mode on ch1, then halted after STOP
        cmd(4'd4, 8'h02, 2'b10, 64'd0);
        cmd(4'd1, 8'h02, 2'b00, 64'd0);
        for (int i = 0; i < 5; i++) pulse(1);
        settle(4);
        cmd(4'd2, 8'h02, 2'b00, 64'h2222_0000_0000_0002);
        get_rec("t2_get_a", rec);
        chk("t2_stop_a", rec, mkrec(64'h2222_0000_0000_0002, 1, 0, 0, 10));
        pulse(1);
        settle(4);
        cmd(4'd2, 8'h02, 2'b00, 64'h2222_0000_0000_0003);
        get_rec("t2_get_b", rec);
        chk("t2_stop_halted", rec, mkrec(64'h2222_0000_0000_0003, 1, 0, 0, 10));

        // Overrun on ch2 while the FIFO is full
        cmd(4'd1, 8'h04, 2'b00, 64'd0);
        for (int i = 0; i < 3; i++) pulse(2);
        settle(4);
        fifo_full = 1'b1;
        cmd(4'd3, 8'h04, 2'b00, 64'h3333_0000_0000_0006);
        pulse(2);
        settle(4);
        cmd(4'd3, 8'h04, 2'b00, 64'h3333_0000_0000_0007);
        settle(5);
        chk("t4_no_write_full", 128'(got_q.size()), 128'd0);
        chk("t4_busy_full", {127'd0, busy}, 128'd1);
        fifo_full = 1'b0;
        get_rec("t4_get", rec);
        chk("t4_ovr_rec", rec, mkrec(64'h3333_0000_0000_0006, 2, 1, 0, 3));
        settle(5);
        chk("t4_one_rec", 128'(got_q.size()), 128'd0);
        cmd(4'd3, 8'h04, 2'b00, 64'h3333_0000_0000_0008);
        get_rec("t4_get_b", rec);
        chk("t4_ovr_cleared", rec, mkrec(64'h3333_0000_0000_0008, 2, 0, 0, 4));

        // Saturation on ch3, then restart clears count and flag
        cmd(4'd1, 8'h08, 2'b00, 64'd0);
        for (int i = 0; i < 20; i++) pulse(3);
        settle(4);
        cmd(4'd3, 8'h08, 2'b00, 64'h4444_0000_0000_0004);
        get_rec("t3_get_a", rec);
        chk("t3_sat", rec, mkrec(64'h4444_0000_0000_0004, 3, 0, 1, 15));
        cmd(4'd1, 8'h08, 2'b00, 64'd0);
        cmd(4'd3, 8'h08, 2'b00, 64'h4444_0000_0000_0005);
        get_rec("t3_get_b", rec);
        chk("t3_restart", rec, mkrec(64'h4444_0000_0000_0005, 3, 0, 0, 0));
        settle(3);

        // Arbitration burst: four back-to-back writes in channel order
        cmd(4'd3, 8'h0F, 2'b00, 64'h5555_0000_0000_0009);
        for (int k = 0; k < 4; k++) begin
            @(negedge rtio_clk);
            chk("t5_burst_write", {127'd0, write}, 128'd1);
            chk("t5_burst_busy", {127'd0, busy}, 128'd1);
        end
        @(negedge rtio_clk);
        chk("t5_burst_end_write", {127'd0, write}, 128'd0);
        chk("t5_burst_end_busy", {127'd0, busy}, 128'd0);
        get_rec("t5_get0", rec);
        chk("t5_ch0", rec, mkrec(64'h5555_0000_0000_0009, 0, 0, 0, 10));
        get_rec("t5_get1", rec);
        chk("t5_ch1", rec, mkrec(64'h5555_0000_0000_0009, 1, 0, 0, 10));
        get_rec("t5_get2", rec);
        chk("t5_ch2", rec, mkrec(64'h5555_0000_0000_0009, 2, 0, 0, 4));
        get_rec("t5_get3", rec);
        chk("t5_ch3", rec, mkrec(64'h5555_0000_0000_0009, 3, 0, 0, 0));

        // Burst with fifo_full toggling
        cmd(4'd3, 8'h0F, 2'b00, 64'h6666_0000_0000_000A);
        for (int i = 0; i < 12; i++) begin
            fifo_full = (i % 3 != 0);
            @(negedge rtio_clk);
        end
        fifo_full = 1'b0;
        settle(3);
        chk("t6_rec_count", 128'(got_q.size()), 128'd4);
        get_rec("t6_get0", rec);
        chk("t6_ch0", rec, mkrec(64'h6666_0000_0000_000A, 0, 0, 0, 10));
        get_rec("t6_get1", rec);
        chk("t6_ch1", rec, mkrec(64'h6666_0000_0000_000A, 1, 0, 0, 10));
        get_rec("t6_get2", rec);
        chk("t6_ch2", rec, mkrec(64'h6666_0000_0000_000A, 2, 0, 0, 4));
        get_rec("t6_get3", rec);
        chk("t6_ch3", rec, mkrec(64'h6666_0000_0000_000A, 3, 0, 0, 0));
        chk("t6_backpressure", 128'(bp_viol), 128'd0);

        // Edge landing in the REPORT cycle is counted
        input_sig[0] = 1'b1;
        settle(2);
        cmd(4'd3, 8'h01, 2'b00, 64'h7777_0000_0000_000B);
        get_rec("t7_get_a", rec);
        chk("t7_edge_report", rec, mkrec(64'h7777_0000_0000_000B, 0, 0, 0, 11));
        input_sig[0] = 1'b0;
        settle(4);
        // Edge landing in the START cycle is not
        input_sig[0] = 1'b1;
        settle(2);
        cmd(4'd1, 8'h01, 2'b00, 64'd0);
        settle(4);
        input_sig[0] = 1'b0;
        settle(4);
        cmd(4'd3, 8'h01, 2'b00, 64'h7777_0000_0000_000C);
        get_rec("t7_get_b", rec);
        chk("t7_edge_start", rec, mkrec(64'h7777_0000_0000_000C, 0, 0, 0, 0));
        settle(3);

        // Asynchronous reset in the middle of a burst
        cmd(4'd3, 8'h0F, 2'b00, 64'h8888_0000_0000_000D);
        @(negedge rtio_clk);
        chk("t8_pre_reset_write", {127'd0, write}, 128'd1);
        #2;
        rtio_resetn = 1'b0;
        #1;
        chk("t8_reset_write", {127'd0, write}, 128'd0);
        chk("t8_reset_count_out", count_out, 128'd0);
        chk("t8_reset_busy", {127'd0, busy}, 128'd0);
        got_q.delete();
        settle(2);
        rtio_resetn = 1'b1;
        settle(10);
        chk("t8_no_records_after", 128'(got_q.size()), 128'd0);
        chk("t8_final_backpressure", 128'(bp_viol), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
